// File: rtl/rf_pkg.sv
// Shared definitions for the register-file scoreboard slice: default sizes and
// the address/data types used at the issue and writeback boundaries.
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW        = $clog2(NREGS_DEF);

    typedef logic [AW-1:0]       reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xlen_t;

endpackage

// File: rtl/rf_scoreboard_if.sv
// Bundle of read, write, issue and status signals between the pipeline and
// the register file.
interface rf_scoreboard_if
    import rf_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 2
);
    localparam int ABITS = $clog2(NREGS);

    logic [NRD*ABITS-1:0] rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;

    logic [NWR-1:0]       wr_en;
    logic [NWR*ABITS-1:0] wr_addr;
    logic [NWR*XLEN-1:0]  wr_data;

    // Issue handshake: a destination is accepted in exactly the cycles where
    // iss_valid && iss_ready at the rising edge; iss_ready never depends on iss_valid.
    logic                 iss_valid;
    logic [ABITS-1:0]     iss_rd;
    logic                 iss_ready;

    logic                 flush;
    logic [ABITS:0]       busy_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_rd, flush,
        input  rd_data, rd_busy, iss_ready, busy_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_rd, flush,
        output rd_data, rd_busy, iss_ready, busy_cnt
    );

endinterface

// File: rtl/rf_wr_arb.sv
// Priority select across write ports for one address: the highest-index
// enabled port writing to addr_i supplies the data.
module rf_wr_arb
    import rf_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int AW_L = AW,
    parameter int NWR  = 2
) (
    input  logic [AW_L-1:0]     addr_i,
    input  logic [NWR-1:0]      wr_en_i,
    input  logic [NWR*AW_L-1:0] wr_addr_i,
    input  logic [NWR*XLEN-1:0] wr_data_i,
    output logic                hit_o,
    output logic [XLEN-1:0]     data_o
);

    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        // Ascending scan so a later (higher) port overrides an earlier match.
        for (int k = 0; k < NWR; k++) begin
            if (wr_en_i[k] && (wr_addr_i[k*AW_L +: AW_L] == addr_i)) begin
                hit_o  = 1'b1;
                data_o = wr_data_i[k*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/rf_scoreboard.sv
// Multi-port integer register file with a per-register busy scoreboard that
// tracks in-flight producers between issue and writeback.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int NREGS   = NREGS_DEF,
    parameter int NRD     = 2,
    parameter int NWR     = 2,
    parameter bit BYPASS  = 1'b1,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    rf_scoreboard_if.slave rf_bus
);

    localparam int ABITS = $clog2(NREGS);
    localparam int CW    = ABITS + 1;

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [CW-1:0]    busy_cnt_q;
    logic [CW-1:0]    busy_cnt_d;

    logic [NREGS-1:0] wr_hit;
    logic [XLEN-1:0]  wr_val [NREGS];

    logic             iss_r0;
    logic             iss_ready;
    logic             iss_fire;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;

    for (genvar r = 0; r < NREGS; r++) begin : g_wr
        rf_wr_arb #(
            .XLEN (XLEN),
            .AW_L (ABITS),
            .NWR  (NWR)
        ) u_wr_arb (
            .addr_i    (ABITS'(r)),
            .wr_en_i   (rf_bus.wr_en),
            .wr_addr_i (rf_bus.wr_addr),
            .wr_data_i (rf_bus.wr_data),
            .hit_o     (wr_hit[r]),
            .data_o    (wr_val[r])
        );
    end

    // A busy destination may still be issued when writeback retires it this cycle.
    assign iss_r0    = ZERO_R0 && (rf_bus.iss_rd == '0);
    assign iss_ready = !rf_bus.flush &&
                       (iss_r0 || !busy_q[rf_bus.iss_rd] || wr_hit[rf_bus.iss_rd]);
    assign iss_fire  = rf_bus.iss_valid && iss_ready;

    always_comb begin
        busy_d = busy_q & ~wr_hit;
        if (iss_fire && !iss_r0) begin
            busy_d[rf_bus.iss_rd] = 1'b1;
        end
        if (ZERO_R0) begin
            busy_d[0] = 1'b0;
        end
        if (rf_bus.flush) begin
            busy_d = '0;
        end
    end

    // Count tracks bits that actually change, so a set/clear collision nets to zero.
    assign set_vec = busy_d & ~busy_q;
    assign clr_vec = busy_q & ~busy_d;

    always_comb begin
        busy_cnt_d = busy_cnt_q;
        for (int r = 0; r < NREGS; r++) begin
            busy_cnt_d = busy_cnt_d + CW'(set_vec[r]) - CW'(clr_vec[r]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (wr_hit[r] && !(ZERO_R0 && (r == 0))) begin
                    regs_q[r] <= wr_val[r];
                end
            end
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [ABITS-1:0] addr;
        logic             byp_hit;
        logic [XLEN-1:0]  byp_data;
        logic [XLEN-1:0]  rd_val;
        logic             rd_bsy;

        assign addr = rf_bus.rd_addr[p*ABITS +: ABITS];

        rf_wr_arb #(
            .XLEN (XLEN),
            .AW_L (ABITS),
            .NWR  (NWR)
        ) u_byp_arb (
            .addr_i    (addr),
            .wr_en_i   (rf_bus.wr_en),
            .wr_addr_i (rf_bus.wr_addr),
            .wr_data_i (rf_bus.wr_data),
            .hit_o     (byp_hit),
            .data_o    (byp_data)
        );

        always_comb begin
            rd_val = regs_q[addr];
            rd_bsy = busy_q[addr];
            if (ZERO_R0 && (addr == '0)) begin
                rd_val = '0;
                rd_bsy = 1'b0;
            end else if (BYPASS && byp_hit) begin
                rd_val = byp_data;
                rd_bsy = 1'b0;
            end
        end

        assign rf_bus.rd_data[p*XLEN +: XLEN] = rd_val;
        assign rf_bus.rd_busy[p]              = rd_bsy;
    end

    assign rf_bus.iss_ready = iss_ready;
    assign rf_bus.busy_cnt  = busy_cnt_q;

endmodule
